// File: rtl/png_chunk_chk.sv
`default_nettype none
// ============================================================================
// Module      : png_chunk_chk
// Description : Byte-serial PNG stream checker. Verifies the 8-byte signature,
//               walks every chunk (length, type, data, CRC), recomputes the
//               CRC-32 over type+data, captures IHDR width/height and forwards
//               IDAT payload bytes downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module png_chunk_chk (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        val_i,
    input  logic [7:0]  dat_i,
    input  logic        lst_i,
    output logic [31:0] w_o,
    output logic [31:0] h_o,
    output logic        hdr_val_o,
    output logic        pld_val_o,
    output logic [7:0]  pld_dat_o,
    output logic        pld_lst_o,
    output logic        chk_val_o,
    output logic [31:0] chk_typ_o,
    output logic        chk_ok_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o
);

    localparam logic [2:0]  c_ST_IDLE = 3'd0;
    localparam logic [2:0]  c_ST_SIG  = 3'd1;
    localparam logic [2:0]  c_ST_LEN  = 3'd2;
    localparam logic [2:0]  c_ST_TYPE = 3'd3;
    localparam logic [2:0]  c_ST_DATA = 3'd4;
    localparam logic [2:0]  c_ST_CRC  = 3'd5;
    localparam logic [2:0]  c_ST_ERR  = 3'd6;

    localparam logic [2:0]  c_E_NONE  = 3'd0;
    localparam logic [2:0]  c_E_SIG   = 3'd1;
    localparam logic [2:0]  c_E_CRC   = 3'd2;
    localparam logic [2:0]  c_E_TRUNC = 3'd3;
    localparam logic [2:0]  c_E_LEN   = 3'd4;
    localparam logic [2:0]  c_E_ORDER = 3'd5;

    localparam logic [31:0] c_POLY    = 32'hEDB88320;
    localparam logic [31:0] c_T_IHDR  = 32'h49484452;
    localparam logic [31:0] c_T_IDAT  = 32'h49444154;
    localparam logic [31:0] c_T_IEND  = 32'h49454E44;

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_len;
    logic [31:0] r_typ;
    logic [31:0] r_crc;
    logic [31:0] r_crx;
    logic        r_first;

    logic [31:0] r_w;
    logic [31:0] r_h;
    logic        r_hdr_val;
    logic        r_pld_val;
    logic [7:0]  r_pld_dat;
    logic        r_pld_lst;
    logic        r_chk_val;
    logic [31:0] r_chk_typ;
    logic        r_chk_ok;
    logic        r_done;
    logic        r_err;
    logic [2:0]  r_err_code;

    logic [7:0]  w_sig_byte;
    logic [31:0] w_crc_seed;
    logic [31:0] w_crc_next;
    logic [31:0] w_len_nx;
    logic [31:0] w_typ_nx;
    logic [31:0] w_crx_nx;
    logic        w_last4;
    logic        w_data_end;
    logic        w_crc_match;
    logic        w_active;
    logic        w_iend_final;
    logic [2:0]  w_ecode;

    // One byte of reflected CRC-32, processed LSB first
    function automatic logic [31:0] f_crc8(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ c_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_crc_seed   = (r_state == c_ST_TYPE && r_cnt == 32'd0) ? 32'hFFFFFFFF : r_crc;
    assign w_crc_next   = f_crc8(w_crc_seed, dat_i);
    assign w_len_nx     = {r_len[23:0], dat_i};
    assign w_typ_nx     = {r_typ[23:0], dat_i};
    assign w_crx_nx     = {r_crx[23:0], dat_i};
    assign w_last4      = (r_cnt == 32'd3);
    assign w_data_end   = (r_cnt == r_len - 32'd1);
    assign w_crc_match  = (w_crx_nx == ~r_crc);
    assign w_active     = (r_state == c_ST_SIG) || (r_state == c_ST_LEN) ||
                          (r_state == c_ST_TYPE) || (r_state == c_ST_DATA) ||
                          (r_state == c_ST_CRC);
    // The only byte allowed to carry lst_i is the final CRC byte of IEND
    assign w_iend_final = (r_state == c_ST_CRC) && w_last4 && (r_typ == c_T_IEND);

    // Expected signature byte for the current position
    always_comb begin
        w_sig_byte = 8'h00;
        case (r_cnt[2:0])
            3'd0: w_sig_byte = 8'h89;
            3'd1: w_sig_byte = 8'h50;
            3'd2: w_sig_byte = 8'h4E;
            3'd3: w_sig_byte = 8'h47;
            3'd4: w_sig_byte = 8'h0D;
            3'd5: w_sig_byte = 8'h0A;
            3'd6: w_sig_byte = 8'h1A;
            3'd7: w_sig_byte = 8'h0A;
            default: w_sig_byte = 8'h00;
        endcase
    end

    // Error classification of the byte on dat_i; stage errors outrank truncation
    always_comb begin
        w_ecode = c_E_NONE;
        case (r_state)
            c_ST_SIG:  if (dat_i != w_sig_byte) w_ecode = c_E_SIG;
            c_ST_LEN:  if (w_last4 && w_len_nx[31]) w_ecode = c_E_LEN;
            c_ST_TYPE: if (w_last4 && r_first && (w_typ_nx != c_T_IHDR)) w_ecode = c_E_ORDER;
            c_ST_CRC:  if (w_last4 && !w_crc_match) w_ecode = c_E_CRC;
            default:   w_ecode = c_E_NONE;
        endcase
        if ((w_ecode == c_E_NONE) && w_active && lst_i && !w_iend_final)
            w_ecode = c_E_TRUNC;
    end

    // Main parser FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 32'd0;
            r_len      <= 32'd0;
            r_typ      <= 32'd0;
            r_crc      <= 32'd0;
            r_crx      <= 32'd0;
            r_first    <= 1'b0;
            r_w        <= 32'd0;
            r_h        <= 32'd0;
            r_hdr_val  <= 1'b0;
            r_pld_val  <= 1'b0;
            r_pld_dat  <= 8'h00;
            r_pld_lst  <= 1'b0;
            r_chk_val  <= 1'b0;
            r_chk_typ  <= 32'd0;
            r_chk_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_E_NONE;
        end else begin
            // Pulse-type outputs idle at zero unless a byte below drives them
            r_pld_val <= 1'b0;
            r_pld_dat <= 8'h00;
            r_pld_lst <= 1'b0;
            r_chk_val <= 1'b0;
            r_chk_typ <= 32'd0;
            r_chk_ok  <= 1'b0;
            r_done    <= 1'b0;

            if (start_i) begin
                r_state    <= c_ST_SIG;
                r_cnt      <= 32'd0;
                r_len      <= 32'd0;
                r_typ      <= 32'd0;
                r_first    <= 1'b1;
                r_w        <= 32'd0;
                r_h        <= 32'd0;
                r_hdr_val  <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= c_E_NONE;
            end else if (val_i) begin
                case (r_state)
                    c_ST_SIG: begin
                        if (r_cnt == 32'd7) begin
                            r_state <= c_ST_LEN;
                            r_cnt   <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_LEN: begin
                        r_len <= w_len_nx;
                        if (w_last4) begin
                            r_state <= c_ST_TYPE;
                            r_cnt   <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_TYPE: begin
                        r_typ <= w_typ_nx;
                        r_crc <= w_crc_next;
                        if (w_last4) begin
                            r_state <= (r_len != 32'd0) ? c_ST_DATA : c_ST_CRC;
                            r_cnt   <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_DATA: begin
                        r_crc <= w_crc_next;
                        if (r_typ == c_T_IHDR) begin
                            if (r_cnt < 32'd4)      r_w <= {r_w[23:0], dat_i};
                            else if (r_cnt < 32'd8) r_h <= {r_h[23:0], dat_i};
                        end
                        if (r_typ == c_T_IDAT) begin
                            r_pld_val <= 1'b1;
                            r_pld_dat <= dat_i;
                            r_pld_lst <= w_data_end;
                        end
                        if (w_data_end) begin
                            r_state <= c_ST_CRC;
                            r_cnt   <= 32'd0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_CRC: begin
                        r_crx <= w_crx_nx;
                        if (w_last4) begin
                            r_chk_val <= 1'b1;
                            r_chk_typ <= r_typ;
                            r_chk_ok  <= w_crc_match;
                            r_first   <= 1'b0;
                            r_cnt     <= 32'd0;
                            if (w_crc_match) begin
                                if (r_typ == c_T_IHDR) r_hdr_val <= 1'b1;
                                if (r_typ == c_T_IEND) begin
                                    r_done  <= 1'b1;
                                    r_state <= c_ST_IDLE;
                                end else begin
                                    r_state <= c_ST_LEN;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: ;
                endcase

                // Any detected error overrides the normal transition
                if (w_ecode != c_E_NONE) begin
                    r_state    <= c_ST_ERR;
                    r_err      <= 1'b1;
                    r_err_code <= w_ecode;
                end
            end
        end
    end

    assign w_o        = r_w;
    assign h_o        = r_h;
    assign hdr_val_o  = r_hdr_val;
    assign pld_val_o  = r_pld_val;
    assign pld_dat_o  = r_pld_dat;
    assign pld_lst_o  = r_pld_lst;
    assign chk_val_o  = r_chk_val;
    assign chk_typ_o  = r_chk_typ;
    assign chk_ok_o   = r_chk_ok;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_png_chunk_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_png_chunk_chk
// Description : Self-checking bench for png_chunk_chk. Builds PNG byte
//               streams, drives them and scores payload/check outputs
//               against expectations queued as each byte is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_png_chunk_chk;

    localparam logic [31:0] c_T_IHDR = 32'h49484452;
    localparam logic [31:0] c_T_IDAT = 32'h49444154;
    localparam logic [31:0] c_T_IEND = 32'h49454E44;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        lst_i;
    logic [31:0] w_o;
    logic [31:0] h_o;
    logic        hdr_val_o;
    logic        pld_val_o;
    logic [7:0]  pld_dat_o;
    logic        pld_lst_o;
    logic        chk_val_o;
    logic [31:0] chk_typ_o;
    logic        chk_ok_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  err_code_o;

    png_chunk_chk dut (
        .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
        .lst_i(lst_i), .w_o(w_o), .h_o(h_o), .hdr_val_o(hdr_val_o),
        .pld_val_o(pld_val_o), .pld_dat_o(pld_dat_o), .pld_lst_o(pld_lst_o),
        .chk_val_o(chk_val_o), .chk_typ_o(chk_typ_o), .chk_ok_o(chk_ok_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dat;
        bit          pld;
        bit          plst;
        bit          chk;
        bit          ok;
        logic [31:0] typ;
    } sb_t;

    typedef struct {
        int          kind;
        int          lst_idx;
        int          exp_lim;
        bit          gaps;
        logic [2:0]  code;
        int          n_chk_e;
        int          n_done_e;
        logic        hdr;
        logic [31:0] w;
        logic [31:0] h;
    } vec_t;

    sb_t         q_file[$];
    logic [7:0]  q_pay[$];
    logic [8:0]  q_pld[$];
    logic [32:0] q_chk[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cnt_chk_pulse = 0;
    int          cnt_done = 0;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
        return c;
    endfunction

    function automatic sb_t mk(input logic [7:0] b);
        sb_t s;
        s = '{dat: b, pld: 1'b0, plst: 1'b0, chk: 1'b0, ok: 1'b0, typ: 32'h0};
        return s;
    endfunction

    // Append a chunk whose data is whatever sits in q_pay
    task automatic add_chunk(input logic [31:0] len, input logic [31:0] typ, input bit corrupt);
        logic [31:0] c;
        logic [31:0] f;
        logic [7:0]  b;
        sb_t         s;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) q_file.push_back(mk(len[31-8*i -: 8]));
        for (int i = 0; i < 4; i++) begin
            b = typ[31-8*i -: 8];
            c = crc_upd(c, b);
            q_file.push_back(mk(b));
        end
        for (int i = 0; i < q_pay.size(); i++) begin
            c = crc_upd(c, q_pay[i]);
            s = mk(q_pay[i]);
            s.pld  = (typ == c_T_IDAT);
            s.plst = (i == q_pay.size() - 1);
            q_file.push_back(s);
        end
        f = ~c ^ {31'b0, corrupt};
        for (int i = 0; i < 4; i++) begin
            s = mk(f[31-8*i -: 8]);
            if (i == 3) begin
                s.chk = 1'b1;
                s.ok  = !corrupt;
                s.typ = typ;
            end
            q_file.push_back(s);
        end
        q_pay.delete();
    endtask

    task automatic add_ihdr(input logic [31:0] w, input logic [31:0] h, input bit corrupt);
        q_pay.delete();
        for (int i = 0; i < 4; i++) q_pay.push_back(w[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) q_pay.push_back(h[31-8*i -: 8]);
        q_pay.push_back(8'h08); q_pay.push_back(8'h06);
        q_pay.push_back(8'h00); q_pay.push_back(8'h00); q_pay.push_back(8'h00);
        add_chunk(32'd13, c_T_IHDR, corrupt);
    endtask

    task automatic add_sig();
        logic [63:0] sig;
        sig = 64'h89504E470D0A1A0A;
        for (int i = 0; i < 8; i++) q_file.push_back(mk(sig[63-8*i -: 8]));
    endtask

    task automatic build(input int kind);
        q_file.delete();
        q_pay.delete();
        add_sig();
        case (kind)
            1: begin add_ihdr(32'd1, 32'd1, 1'b1); add_chunk(32'd0, c_T_IEND, 1'b0); end
            2: begin
                add_ihdr(32'd1, 32'd1, 1'b0);
                for (int i = 1; i <= 5; i++) q_pay.push_back(8'(i));
                add_chunk(32'd5, c_T_IDAT, 1'b0);
                add_chunk(32'd0, c_T_IEND, 1'b0);
            end
            3: begin
                add_ihdr(32'd1, 32'd1, 1'b0); add_chunk(32'd0, c_T_IEND, 1'b0);
                q_file[2].dat = 8'h4F;
            end
            5: add_chunk(32'd0, c_T_IEND, 1'b0);
            6: begin add_chunk(32'h80000000, c_T_IHDR, 1'b0); add_chunk(32'd0, c_T_IEND, 1'b0); end
            7: begin
                add_ihdr(32'h12345678, 32'h9ABCDEF0, 1'b0);
                add_chunk(32'd0, 32'h61624344, 1'b0);
                add_chunk(32'd0, c_T_IEND, 1'b0);
            end
            default: begin add_ihdr(32'd1, 32'd1, 1'b0); add_chunk(32'd0, c_T_IEND, 1'b0); end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lst);
        val_i = 1'b1; dat_i = b; lst_i = lst;
        @(posedge clk); #1;
        val_i = 1'b0; lst_i = 1'b0; dat_i = 8'h00;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; val_i = 1'b1; dat_i = 8'h89;
        @(posedge clk); #1;
        start_i = 1'b0; val_i = 1'b0; dat_i = 8'h00;
    endtask

    task automatic run(input vec_t v, input string tag);
        int lst_at;
        build(v.kind);
        q_pld.delete(); q_chk.delete();
        cnt_chk_pulse = 0; cnt_done = 0;
        lst_at = (v.lst_idx < 0) ? q_file.size() - 1 : v.lst_idx;
        pulse_start();
        check({tag, "_start_err"}, {31'b0, err_o}, 32'd0);
        for (int i = 0; i < q_file.size(); i++) begin
            if (v.gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (v.exp_lim < 0 || i < v.exp_lim) begin
                if (q_file[i].pld) q_pld.push_back({q_file[i].plst, q_file[i].dat});
                if (q_file[i].chk) q_chk.push_back({q_file[i].ok, q_file[i].typ});
            end
            send_byte(q_file[i].dat, i == lst_at);
        end
        // Trailing bytes after the file must be ignored
        send_byte(8'h89, 1'b0); send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_err_code"}, {29'b0, err_code_o}, {29'b0, v.code});
        check({tag, "_err"}, {31'b0, err_o}, {31'b0, (v.code != 3'd0)});
        check({tag, "_n_chk"}, cnt_chk_pulse, v.n_chk_e);
        check({tag, "_n_done"}, cnt_done, v.n_done_e);
        check({tag, "_hdr_val"}, {31'b0, hdr_val_o}, {31'b0, v.hdr});
        check({tag, "_w"}, w_o, v.w);
        check({tag, "_h"}, h_o, v.h);
        check({tag, "_pld_left"}, q_pld.size(), 0);
        check({tag, "_chk_left"}, q_chk.size(), 0);
    endtask

    // Scoreboard: pop expectations as the DUT emits payload and check results
    always @(negedge clk) begin
        logic [8:0]  ep;
        logic [32:0] ec;
        if (!rst) begin
            if (pld_val_o) begin
                check("pld_pending", {31'b0, (q_pld.size() > 0)}, 32'd1);
                if (q_pld.size() > 0) begin
                    ep = q_pld.pop_front();
                    check("pld_dat", {24'b0, pld_dat_o}, {24'b0, ep[7:0]});
                    check("pld_lst", {31'b0, pld_lst_o}, {31'b0, ep[8]});
                end
            end
            if (chk_val_o) begin
                cnt_chk_pulse++;
                check("chk_pending", {31'b0, (q_chk.size() > 0)}, 32'd1);
                if (q_chk.size() > 0) begin
                    ec = q_chk.pop_front();
                    check("chk_typ", chk_typ_o, ec[31:0]);
                    check("chk_ok", {31'b0, chk_ok_o}, {31'b0, ec[32]});
                end
            end
            if (done_o) cnt_done++;
        end
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  ihdr_b [0:16];
        logic [31:0] ihdr_w;

        // kind, lst_idx, exp_lim, gaps, code, n_chk, n_done, hdr, w, h
        tbl[0] = '{0, -1, -1, 1'b0, 3'd0, 2, 1, 1'b1, 32'd1, 32'd1};
        tbl[1] = '{1, -1, 33, 1'b0, 3'd2, 1, 0, 1'b0, 32'd1, 32'd1};
        tbl[2] = '{2, -1, -1, 1'b1, 3'd0, 3, 1, 1'b1, 32'd1, 32'd1};
        tbl[3] = '{3, -1,  2, 1'b0, 3'd1, 0, 0, 1'b0, 32'd0, 32'd0};
        tbl[4] = '{0, -1, -1, 1'b1, 3'd0, 2, 1, 1'b1, 32'd1, 32'd1};
        tbl[5] = '{0, 42, 43, 1'b0, 3'd3, 1, 0, 1'b1, 32'd1, 32'd1};
        tbl[6] = '{5, -1, 16, 1'b0, 3'd5, 0, 0, 1'b0, 32'd0, 32'd0};
        tbl[7] = '{6, -1, 12, 1'b0, 3'd4, 0, 0, 1'b0, 32'd0, 32'd0};
        tbl[8] = '{7, -1, -1, 1'b1, 3'd0, 3, 1, 1'b1, 32'h12345678, 32'h9ABCDEF0};

        // Reference CRC helper against well-known PNG chunk CRCs
        ihdr_w = c_T_IHDR;
        for (int i = 0; i < 4; i++) ihdr_b[i] = ihdr_w[31-8*i -: 8];
        ihdr_b[4] = 8'h00; ihdr_b[5] = 8'h00; ihdr_b[6] = 8'h00; ihdr_b[7] = 8'h01;
        ihdr_b[8] = 8'h00; ihdr_b[9] = 8'h00; ihdr_b[10] = 8'h00; ihdr_b[11] = 8'h01;
        ihdr_b[12] = 8'h08; ihdr_b[13] = 8'h06; ihdr_b[14] = 8'h00; ihdr_b[15] = 8'h00;
        ihdr_b[16] = 8'h00;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 17; i++) c = crc_upd(c, ihdr_b[i]);
        check("ref_crc_ihdr", ~c, 32'h1F15C489);

        rst = 1'b1; start_i = 1'b0; val_i = 1'b0; dat_i = 8'h00; lst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {31'b0, |{w_o, h_o, hdr_val_o, pld_val_o, pld_dat_o, pld_lst_o,
              chk_val_o, chk_typ_o, chk_ok_o, done_o, err_o, err_code_o}}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Bytes in IDLE before any start must be ignored
        send_byte(8'h00, 1'b1);
        check("idle_ignore_err", {31'b0, err_o}, 32'd0);

        for (int t = 0; t < 9; t++) run(tbl[t], $sformatf("v%0d", t));

        // Signature error timing and post-error deafness
        pulse_start();
        send_byte(8'h89, 1'b0);
        send_byte(8'h50, 1'b0);
        check("sig_pre_err", {31'b0, err_o}, 32'd0);
        send_byte(8'h4F, 1'b0);
        check("sig_err_latency", {29'b0, err_code_o}, 32'd1);
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9);
        check("sig_err_sticky", {29'b0, err_code_o}, 32'd1);

        // Asynchronous reset in the middle of IHDR data
        pulse_start();
        build(0);
        for (int i = 0; i < 16; i++) send_byte(q_file[i].dat, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b0);
        check("mid_w_partial", w_o, 32'h00123456);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {31'b0, |{w_o, h_o, hdr_val_o, pld_val_o, pld_dat_o, pld_lst_o,
              chk_val_o, chk_typ_o, chk_ok_o, done_o, err_o, err_code_o}}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(tbl[0], "post_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/png_chunk_chk.md
# png_chunk_chk

Byte-serial PNG stream checker: the receive-side counterpart of the chunk CRC32 generator. It consumes a complete PNG file one byte per cycle and verifies the 8-byte signature. It parses every chunk's length and type, recomputes CRC-32 over type plus data, and compares it with the trailing CRC field. It captures IHDR width and height and forwards IDAT payload bytes to the downstream inflater.

## Interface
- No parameters. Data width is fixed at 8 bits; size fields are fixed at 32 bits.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that arms the checker; the byte presented in the same cycle is discarded
- val_i  in  1  dat_i valid; accepted every valid cycle, no backpressure
- dat_i  in  8  stream byte in file order
- lst_i  in  1  marks the final byte of the file
- w_o  out  32  IHDR width, big-endian assembled
- h_o  out  32  IHDR height
- hdr_val_o  out  1  level; high once the IHDR CRC has passed
- pld_val_o  out  1  IDAT payload byte valid
- pld_dat_o  out  8  IDAT payload byte
- pld_lst_o  out  1  last payload byte of the current IDAT chunk
- chk_val_o  out  1  one-cycle pulse when a chunk's CRC comparison completes
- chk_typ_o  out  32  type of the chunk just checked
- chk_ok_o  out  1  CRC match, qualified by chk_val_o
- done_o  out  1  one-cycle pulse when the IEND CRC passes
- err_o  out  1  sticky error flag, cleared only by start_i or rst
- err_code_o  out  3  error code: 0 none, 1 SIG, 2 CRC, 3 TRUNC, 4 LEN, 5 ORDER

## Operation
- **States:** IDLE, SIG, LEN, TYPE, DATA, CRC, ERR.
- **Byte counter:** one 32-bit counter is reused by every state.
- **Reset:** every output resets to 0, and the state resets to IDLE.
- **IDLE:**
  - val_i is ignored.
  - start_i moves to SIG with count 0 and clears err_o, err_code_o, hdr_val_o, w_o and h_o.
- **start_i priority:** start_i in any state forces a restart and has priority over val_i.
- **SIG:**
  - Eight bytes are compared with 89 50 4E 47 0D 0A 1A 0A.
  - The first mismatching byte sends the FSM to ERR with code 1.
  - After all eight match, go to LEN.
- **LEN:**
  - Four bytes are shifted into len_r, MSB first.
  - If len_r[31]=1 after the 4th byte, go to ERR with code 4.
- **TYPE:**
  - Four bytes are shifted into typ_r.
  - CRC register is initialised to FFFFFFFF on the first TYPE byte, then updated with each type byte.
  - If this is the first chunk and the type is not 49484452 ("IHDR"), go to ERR with code 5.
  - After the 4th byte, go to DATA if len_r≠0, otherwise to CRC.
- **DATA:**
  - len_r bytes are folded into the CRC.
  - IHDR: bytes 0–3 load w_o and bytes 4–7 load h_o.
  - IDAT (49444154): each byte is forwarded on the payload port.
  - Other types are checked but not forwarded.
- **CRC:**
  - Four bytes are assembled, MSB first.
  - Comparison is against CRC register XOR FFFFFFFF.
  - On compare: pulse chk_val_o, drive chk_typ_o=typ_r and chk_ok_o.
  - Mismatch: go to ERR with code 2.
  - IHDR match: set hdr_val_o.
  - IEND (49454E44) match: pulse done_o and return to IDLE.
  - Any other match: go to LEN.
- **CRC math:**
  - Reflected polynomial EDB88320.
  - Each byte is processed LSB-first, 8 bit-steps combinationally per cycle.
- **Truncation:** lst_i on any accepted byte other than the 4th IEND CRC byte sends the FSM to ERR with code 3. If a CRC mismatch occurs in the same cycle, code 2 wins.
- **ERR:** all input is ignored until start_i. Payload and chk outputs are held at 0.
- **After IEND:** bytes following IEND are ignored in IDLE.

## Timing
- Every output is registered, with 1 cycle of latency from the accepting edge.
- pld_val_o/pld_dat_o/pld_lst_o appear one cycle after the IDAT byte is accepted. pld_lst_o accompanies byte len_r−1.
- chk_val_o, chk_ok_o and done_o appear one cycle after the 4th CRC byte.
- err_o rises one cycle after the offending byte.
- w_o/h_o update one cycle after each IHDR width/height byte and hold until start_i or rst.
- Gaps in val_i are allowed anywhere; state and counters hold while val_i=0.
- rst mid-stream clears everything immediately and asynchronously.
- Zero-length chunks take exactly 4 TYPE bytes followed by 4 CRC bytes.

## Test plan
- **Minimal valid file:**
  - Stimulus: signature; IHDR 0000000D 49484452 00000001 00000001 08 06 00 00 00, CRC 1F15C489; IEND 00000000 49454E44 AE426082 with lst_i on the last byte.
  - Response:
    - w_o=1, h_o=1, hdr_val_o=1.
    - Two chk_val_o pulses, both with chk_ok_o=1.
    - done_o pulses once; err_o=0.
- **Corrupted IHDR CRC:** same file with the IHDR CRC changed to 1F15C488.
  - chk_ok_o=0 with chk_typ_o=49484452.
  - err_code_o=2; done_o never asserts.
- **IDAT passthrough:**
  - Stimulus: an IDAT chunk of length 5, bytes 01..05, with a correct CRC, sent with random val_i gaps.
  - Response: exactly 5 pld_val_o pulses carrying 01..05, with pld_lst_o on 05; chk_ok_o=1.
- **Signature error:** 3rd byte is 4F instead of 4E.
  - err_code_o=1 one cycle later.
  - All later bytes are ignored; a subsequent start_i plus a valid file passes.
- **Truncation:** lst_i asserted on the 2nd IEND CRC byte.
  - err_code_o=3 and done_o=0.
- **Order and reset:**
  - First chunk typed IEND → err_code_o=5.
  - Separately, rst asserted mid-DATA → all outputs are 0 in the same cycle, and the next start_i runs a clean pass.
